bus_controller: RTL and testbench

- Parametrised successor to the fixed-decode 68000 glue controller.
- Divides the source clock to produce the CPU clock, decodes chip selects, and drives CPU DTACK/VPA/BERR.
- DTACK/VPA/BERR come from a bus-cycle FSM with per-region wait states and a bus-error watchdog.
- Also encodes and masks seven interrupt sources onto IPL, and hosts readable LED/GPIO/IRQ-mask registers in the 0xF0xxxx I/O page.

---
 rtl/bus_controller_pkg.sv | 50 +++++
 rtl/bus_controller_irq_encoder.sv | 44 ++++
 rtl/bus_controller.sv | 251 +++++++++++++++++++++++++
 tb/tb_bus_controller.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_controller_pkg.sv
// Shared types and constants for the 68000 bus controller: region map,
// FSM encodings, I/O register offsets and the interrupt-acknowledge function code.
package bus_controller_pkg;

    typedef enum logic [2:0] {
        REG_ROM,
        REG_RAM,
        REG_DUART,
        REG_EXP,
        REG_IO,
        REG_NONE
    } region_e;

    localparam logic [3:0] BASE_ROM   = 4'h0;
    localparam logic [3:0] BASE_RAM   = 4'h8;
    localparam logic [3:0] BASE_DUART = 4'hC;
    localparam logic [3:0] BASE_EXP   = 4'hE;
    localparam logic [3:0] BASE_IO    = 4'hF;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_ACK    = 3'd3;
    localparam logic [2:0] ST_ERR    = 3'd4;

    // Offsets are A4..A1 of the odd byte address inside the I/O page
    localparam logic [3:0] IO_OFS_LED  = 4'h0;
    localparam logic [3:0] IO_OFS_GPIO = 4'h1;
    localparam logic [3:0] IO_OFS_MASK = 4'h2;

    localparam logic [2:0] FC_IACK     = 3'b111;
    localparam logic [3:0] IACK_A19_16 = 4'hF;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned WS_W        = 8;

    function automatic region_e decode_region(input logic [3:0] a23_20);
        region_e r;
        case (a23_20)
            BASE_ROM:   r = REG_ROM;
            BASE_RAM:   r = REG_RAM;
            BASE_DUART: r = REG_DUART;
            BASE_EXP:   r = REG_EXP;
            BASE_IO:    r = REG_IO;
            default:    r = REG_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bus_controller_irq_encoder.sv
// Synchronises the seven active-low interrupt requests, applies the mask
// (level 7 is never masked) and registers the active-low encoded IPL.
module irq_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] irq_n,
    input  logic [5:0] mask,
    output logic [2:0] ipl
);

    logic [6:0] irq_s1_q, irq_s1_d;
    logic [6:0] irq_s2_q, irq_s2_d;
    logic [2:0] ipl_q, ipl_d;
    logic [6:0] eff;
    logic [2:0] level;

    always_comb begin
        irq_s1_d = irq_n;
        irq_s2_d = irq_s1_q;
        eff      = ~irq_s2_q & {1'b1, mask};
        level    = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (eff[i]) begin
                level = 3'(i + 1);
            end
        end
        ipl_d = ~level;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_s1_q <= 7'h7F;
            irq_s2_q <= 7'h7F;
            ipl_q    <= 3'b111;
        end else begin
            irq_s1_q <= irq_s1_d;
            irq_s2_q <= irq_s2_d;
            ipl_q    <= ipl_d;
        end
    end

    assign ipl = ipl_q;

endmodule

// File: rtl/bus_controller.sv
// 68000 glue controller: CPU clock divider, chip-select decode, bus-cycle FSM
// with per-region wait states and watchdog, I/O page registers and IPL encoding.
module bus_controller
    import bus_controller_pkg::*;
#(
    parameter int unsigned CLK_DIV_LOG2    = 3,
    parameter int unsigned GPIO_WIDTH      = 8,
    parameter int unsigned ROM_WS          = 1,
    parameter int unsigned RAM_WS          = 0,
    parameter int unsigned DUART_WS        = 3,
    parameter int unsigned EXP_WS          = 7,
    parameter int unsigned BERR_TIMEOUT    = 255,
    parameter int unsigned DUART_IRQ_LEVEL = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    output logic                  CLK_CPU,
    input  logic [9:0]            ADDR_H,
    input  logic [3:0]            ADDR_L,
    input  logic                  AS,
    input  logic                  UDS,
    input  logic                  LDS,
    input  logic                  RW,
    input  logic [2:0]            FC,
    input  logic [7:0]            DATA_IN,
    output logic [7:0]            DATA_OUT,
    output logic                  DATA_OE,
    input  logic [6:0]            IRQ_N,
    output logic [2:0]            IPL,
    output logic                  DTACK,
    output logic                  VPA,
    output logic                  BERR,
    output logic                  ROM_LOWER,
    output logic                  ROM_UPPER,
    output logic                  RAM_LOWER,
    output logic                  RAM_UPPER,
    output logic                  DUART,
    output logic                  EXP,
    output logic                  IACK_DUART,
    output logic [2:0]            LED,
    output logic [GPIO_WIDTH-1:0] GPIO
);

    logic [CLK_DIV_LOG2-1:0] div_q, div_d;
    logic                    as_s1_q, as_s1_d, as_q, as_d;
    logic                    lds_s1_q, lds_s1_d, lds_q, lds_d;
    logic [2:0]              state_q, state_d;
    logic [WS_W-1:0]         wait_q, wait_d;
    logic [7:0]              wd_q, wd_d;
    logic                    iack_duart_q, iack_duart_d;
    logic                    autovec_q, autovec_d;
    logic                    io_q, io_d;
    logic                    rd_q, rd_d;
    logic [2:0]              led_q, led_d;
    logic [GPIO_WIDTH-1:0]   gpio_q, gpio_d;
    logic [6:0]              mask_q, mask_d;
    logic [7:0]              data_out_q, data_out_d;

    region_e         region_c;
    logic            is_iack_c;
    logic            as_act_c;
    logic            io_ofs_ok_c;
    logic [7:0]      rdata_c;
    logic [WS_W-1:0] region_ws_c;
    logic [7:0]      wd_inc_c;
    logic            timeout_c;
    logic            ack_entry_c;
    logic            ack_active_c;

    // Address decode; FC=111 never selects memory, only the IACK path
    always_comb begin
        is_iack_c   = (FC == FC_IACK) && (ADDR_H[5:2] == IACK_A19_16);
        region_c    = (FC == FC_IACK) ? REG_NONE : decode_region(ADDR_H[9:6]);
        as_act_c    = !AS && !RST;
        io_ofs_ok_c = (ADDR_H[5:0] == 6'd0);
        case (region_c)
            REG_ROM:   region_ws_c = WS_W'(ROM_WS);
            REG_RAM:   region_ws_c = WS_W'(RAM_WS);
            REG_DUART: region_ws_c = WS_W'(DUART_WS);
            REG_EXP:   region_ws_c = WS_W'(EXP_WS);
            default:   region_ws_c = '0;
        endcase
        rdata_c = 8'h00;
        if (io_ofs_ok_c) begin
            case (ADDR_L)
                IO_OFS_LED:  rdata_c = 8'(led_q);
                IO_OFS_GPIO: rdata_c = 8'(gpio_q);
                IO_OFS_MASK: rdata_c = 8'(mask_q);
                default:     rdata_c = 8'h00;
            endcase
        end
    end

    assign ROM_LOWER = !(as_act_c && !LDS && (region_c == REG_ROM));
    assign ROM_UPPER = !(as_act_c && !UDS && (region_c == REG_ROM));
    assign RAM_LOWER = !(as_act_c && !LDS && (region_c == REG_RAM));
    assign RAM_UPPER = !(as_act_c && !UDS && (region_c == REG_RAM));
    assign DUART     = !(as_act_c && !LDS && (region_c == REG_DUART));
    assign EXP       = !(as_act_c && (region_c == REG_EXP));

    // Bus-cycle FSM and watchdog
    always_comb begin
        div_d        = div_q + CLK_DIV_LOG2'(1);
        as_s1_d      = AS;
        as_d         = as_s1_q;
        lds_s1_d     = LDS;
        lds_d        = lds_s1_q;
        state_d      = state_q;
        wait_d       = wait_q;
        wd_d         = wd_q;
        iack_duart_d = iack_duart_q;
        autovec_d    = autovec_q;
        io_d         = io_q;
        rd_d         = rd_q;
        wd_inc_c     = (wd_q == 8'hFF) ? wd_q : wd_q + 8'd1;
        timeout_c    = (wd_inc_c >= 8'(BERR_TIMEOUT));

        case (state_q)
            ST_IDLE: begin
                iack_duart_d = 1'b0;
                autovec_d    = 1'b0;
                io_d         = 1'b0;
                if (!as_q) begin
                    state_d = ST_DECODE;
                    // Preload with the synchroniser latency so the timeout runs from AS
                    wd_d    = 8'(SYNC_STAGES);
                end
            end
            ST_DECODE: begin
                wd_d = wd_inc_c;
                rd_d = RW;
                if (timeout_c) begin
                    state_d = ST_ERR;
                end else if (is_iack_c) begin
                    if (ADDR_L[2:0] == 3'(DUART_IRQ_LEVEL)) begin
                        iack_duart_d = 1'b1;
                        wait_d       = WS_W'(DUART_WS);
                        state_d      = ST_WAIT;
                    end else begin
                        autovec_d = 1'b1;
                        state_d   = ST_ACK;
                    end
                end else if (region_c == REG_NONE) begin
                    state_d = ST_ERR;
                end else begin
                    io_d    = (region_c == REG_IO);
                    wait_d  = region_ws_c;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wd_d = wd_inc_c;
                if (as_q) begin
                    state_d = ST_IDLE;
                end else if (timeout_c) begin
                    state_d = ST_ERR;
                end else if (wait_q == '0) begin
                    state_d = ST_ACK;
                end else begin
                    wait_d = wait_q - WS_W'(1);
                end
            end
            ST_ACK: begin
                if (as_q) state_d = ST_IDLE;
            end
            ST_ERR: begin
                if (as_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // I/O page register writes and readback capture on ACK entry
    always_comb begin
        led_d       = led_q;
        gpio_d      = gpio_q;
        mask_d      = mask_q;
        data_out_d  = data_out_q;
        ack_entry_c = (state_d == ST_ACK) && (state_q != ST_ACK);
        if (ack_entry_c && io_q && !rd_q && !lds_q && io_ofs_ok_c) begin
            case (ADDR_L)
                IO_OFS_LED:  led_d  = DATA_IN[2:0];
                IO_OFS_GPIO: gpio_d = DATA_IN[GPIO_WIDTH-1:0];
                IO_OFS_MASK: mask_d = DATA_IN[6:0];
                default:     led_d  = led_q;
            endcase
        end
        if (ack_entry_c && io_q && rd_q) begin
            data_out_d = rdata_c;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_q        <= '0;
            as_s1_q      <= 1'b1;
            as_q         <= 1'b1;
            lds_s1_q     <= 1'b1;
            lds_q        <= 1'b1;
            state_q      <= ST_IDLE;
            wait_q       <= '0;
            wd_q         <= '0;
            iack_duart_q <= 1'b0;
            autovec_q    <= 1'b0;
            io_q         <= 1'b0;
            rd_q         <= 1'b1;
            led_q        <= '0;
            gpio_q       <= '0;
            mask_q       <= 7'h7F;
            data_out_q   <= '0;
        end else begin
            div_q        <= div_d;
            as_s1_q      <= as_s1_d;
            as_q         <= as_d;
            lds_s1_q     <= lds_s1_d;
            lds_q        <= lds_d;
            state_q      <= state_d;
            wait_q       <= wait_d;
            wd_q         <= wd_d;
            iack_duart_q <= iack_duart_d;
            autovec_q    <= autovec_d;
            io_q         <= io_d;
            rd_q         <= rd_d;
            led_q        <= led_d;
            gpio_q       <= gpio_d;
            mask_q       <= mask_d;
            data_out_q   <= data_out_d;
        end
    end

    // Acknowledges drop as soon as the synchronised AS returns high
    assign ack_active_c = (state_q == ST_ACK) && !as_q;
    assign DTACK        = !(ack_active_c && !autovec_q);
    assign VPA          = !(ack_active_c && autovec_q);
    assign BERR         = !((state_q == ST_ERR) && !as_q);
    assign IACK_DUART   = !(iack_duart_q && ((state_q == ST_WAIT) || ack_active_c));
    assign DATA_OE      = ack_active_c && io_q && rd_q;
    assign DATA_OUT     = data_out_q;
    assign CLK_CPU      = div_q[CLK_DIV_LOG2-1];
    assign LED          = led_q;
    assign GPIO         = gpio_q;

    irq_encoder u_irq (
        .clk   (CLK),
        .rst   (RST),
        .irq_n (IRQ_N),
        .mask  (mask_q[5:0]),
        .ipl   (IPL)
    );

endmodule

// File: tb/tb_bus_controller.sv
// Scoreboard bench for bus_controller: bus cycles, I/O registers, IRQ encoding,
// watchdog and asynchronous reset.
module tb_bus_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_cpu;
    logic [9:0] addr_h = '0;
    logic [3:0] addr_l = '0;
    logic       as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1;
    logic [2:0] fc = 3'b101;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       data_oe;
    logic [6:0] irq_n = 7'h7F;
    logic [2:0] ipl;
    logic       dtack, vpa, berr;
    logic       rom_lower, rom_upper, ram_lower, ram_upper, duart, exp_cs;
    logic       iack_duart;
    logic [2:0] led;
    logic [7:0] gpio;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string      name;
        int         lat;
        logic [2:0] kind;   // {BERR, VPA, DTACK} asserted
        logic [5:0] cs;     // {ROM_L, ROM_U, RAM_L, RAM_U, DUART, EXP}
        logic       oe;
        logic [7:0] data;
        logic       iack;
    } cyc_t;

    typedef struct {
        string       name;
        logic [31:0] val;
    } val_t;

    cyc_t cyc_q[$];
    val_t val_q[$];

    bus_controller #(.ROM_WS(20), .BERR_TIMEOUT(16)) dut (
        .CLK(clk), .RST(rst), .CLK_CPU(clk_cpu),
        .ADDR_H(addr_h), .ADDR_L(addr_l),
        .AS(as_n), .UDS(uds_n), .LDS(lds_n), .RW(rw), .FC(fc),
        .DATA_IN(data_in), .DATA_OUT(data_out), .DATA_OE(data_oe),
        .IRQ_N(irq_n), .IPL(ipl),
        .DTACK(dtack), .VPA(vpa), .BERR(berr),
        .ROM_LOWER(rom_lower), .ROM_UPPER(rom_upper),
        .RAM_LOWER(ram_lower), .RAM_UPPER(ram_upper),
        .DUART(duart), .EXP(exp_cs), .IACK_DUART(iack_duart),
        .LED(led), .GPIO(gpio)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // One full CPU cycle; latency counted in CLK edges after the edge that first samples AS low
    task automatic bus_cycle(input string name, input logic [23:0] addr, input logic [2:0] fcv,
                             input logic rwv, input logic u, input logic l, input logic [7:0] wd,
                             input int lat, input logic [2:0] kind, input logic [5:0] cs,
                             input logic oe, input logic [7:0] data, input logic iack);
        cyc_t e;
        cyc_t g;
        int n;
        logic [2:0] obs_kind;
        logic [5:0] obs_cs;
        e = '{name, lat, kind, cs, oe, data, iack};
        cyc_q.push_back(e);
        @(negedge clk);
        addr_h = addr[23:14]; addr_l = addr[4:1]; fc = fcv; rw = rwv;
        data_in = wd; uds_n = u; lds_n = l; as_n = 1'b0;
        #1;
        g = cyc_q.pop_front();
        obs_cs = {rom_lower, rom_upper, ram_lower, ram_upper, duart, exp_cs};
        vectors++;
        if (obs_cs !== g.cs) begin
            miscompares++;
            $display("FAIL %s_cs: got %b expected %b", g.name, obs_cs, g.cs);
        end
        @(posedge clk);
        n = 0;
        while (n < 64) begin
            @(posedge clk); #1; n++;
            if ({berr, vpa, dtack} != 3'b111) break;
        end
        obs_kind = ~{berr, vpa, dtack};
        vectors++;
        if (obs_kind !== g.kind) begin
            miscompares++;
            $display("FAIL %s_kind: got %b expected %b", g.name, obs_kind, g.kind);
        end
        vectors++;
        if (n != g.lat) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d expected %0d", g.name, n, g.lat);
        end
        vectors++;
        if (data_oe !== g.oe) begin
            miscompares++;
            $display("FAIL %s_oe: got %b expected %b", g.name, data_oe, g.oe);
        end
        if (g.oe) begin
            vectors++;
            if (data_out !== g.data) begin
                miscompares++;
                $display("FAIL %s_data: got %h expected %h", g.name, data_out, g.data);
            end
        end
        vectors++;
        if (!iack_duart !== g.iack) begin
            miscompares++;
            $display("FAIL %s_iack: got %b expected %b", g.name, !iack_duart, g.iack);
        end
        @(negedge clk);
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
        @(posedge clk);
        n = 0;
        while (n < 8) begin
            @(posedge clk); #1; n++;
            if ({berr, vpa, dtack, iack_duart, data_oe} == 5'b11110) break;
        end
        vectors++;
        if (n > 2) begin
            miscompares++;
            $display("FAIL %s_release: strobes high after %0d clk, required <= 2", g.name, n);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({dtack, vpa, berr, iack_duart, rom_lower, rom_upper, ram_lower, ram_upper, duart, exp_cs}
            !== 10'h3FF) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b expected all ones",
                     {dtack, vpa, berr, iack_duart, rom_lower, rom_upper, ram_lower, ram_upper, duart, exp_cs});
        end
        vectors++;
        if ({data_oe, clk_cpu, led, gpio, ipl} !== {1'b0, 1'b0, 3'd0, 8'd0, 3'b111}) begin
            miscompares++;
            $display("FAIL reset_regs: oe=%b clk_cpu=%b led=%h gpio=%h ipl=%b", data_oe, clk_cpu, led, gpio, ipl);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (clk_cpu !== ((k % 8) >= 4)) begin
                miscompares++;
                $display("FAIL clk_cpu_%0d: got %b expected %b", k, clk_cpu, (k % 8) >= 4);
            end
        end
    endtask

    task automatic test_memory();
        bus_cycle("ram_rd", 24'h800000, 3'b101, 1, 0, 0, 8'h00, 4, 3'b001, 6'b110011, 0, 8'h00, 0);
        bus_cycle("duart_lds", 24'hC00001, 3'b101, 1, 1, 0, 8'h00, 7, 3'b001, 6'b111101, 0, 8'h00, 0);
        bus_cycle("duart_uds", 24'hC00000, 3'b101, 1, 0, 1, 8'h00, 7, 3'b001, 6'b111111, 0, 8'h00, 0);
        bus_cycle("exp_rd", 24'hE00000, 3'b101, 1, 0, 0, 8'h00, 11, 3'b001, 6'b111110, 0, 8'h00, 0);
    endtask

    task automatic test_io_regs();
        val_t v;
        bus_cycle("mask_rst_rd", 24'hF00005, 3'b101, 1, 1, 0, 8'h00, 4, 3'b001, 6'h3F, 1, 8'h7F, 0);
        bus_cycle("led_wr", 24'hF00001, 3'b101, 0, 1, 0, 8'h05, 4, 3'b001, 6'h3F, 0, 8'h00, 0);
        bus_cycle("gpio_wr", 24'hF00003, 3'b101, 0, 1, 0, 8'hA5, 4, 3'b001, 6'h3F, 0, 8'h00, 0);
        bus_cycle("bad_wr", 24'hF00011, 3'b101, 0, 1, 0, 8'hFF, 4, 3'b001, 6'h3F, 0, 8'h00, 0);
        val_q.push_back('{"led_port", 32'h5});
        val_q.push_back('{"gpio_port", 32'hA5});
        v = val_q.pop_front();
        vectors++;
        if (32'(led) !== v.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", v.name, led, v.val);
        end
        v = val_q.pop_front();
        vectors++;
        if (32'(gpio) !== v.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", v.name, gpio, v.val);
        end
        bus_cycle("led_rd", 24'hF00001, 3'b101, 1, 1, 0, 8'h00, 4, 3'b001, 6'h3F, 1, 8'h05, 0);
        bus_cycle("gpio_rd", 24'hF00003, 3'b101, 1, 1, 0, 8'h00, 4, 3'b001, 6'h3F, 1, 8'hA5, 0);
        bus_cycle("bad_rd", 24'hF00011, 3'b101, 1, 1, 0, 8'h00, 4, 3'b001, 6'h3F, 1, 8'h00, 0);
    endtask

    task automatic test_irq();
        val_t v;
        logic [6:0] irqs [4] = '{7'b1101011, 7'b1101011, 7'b1101011, 7'b0101011};
        logic [7:0] masks[4] = '{8'h7F, 8'h6F, 8'h00, 8'h00};
        logic [2:0] ipls [4] = '{3'b010, 3'b100, 3'b111, 3'b000};
        for (int i = 0; i < 4; i++) begin
            val_q.push_back('{$sformatf("ipl_%0d", i), 32'(ipls[i])});
            irq_n = irqs[i];
            bus_cycle($sformatf("mask_wr_%0d", i), 24'hF00005, 3'b101, 0, 1, 0, masks[i],
                      4, 3'b001, 6'h3F, 0, 8'h00, 0);
            repeat (4) @(posedge clk);
            #1;
            v = val_q.pop_front();
            vectors++;
            if (32'(ipl) !== v.val) begin
                miscompares++;
                $display("FAIL %s: got %b expected %b", v.name, ipl, v.val[2:0]);
            end
        end
    endtask

    task automatic test_iack();
        bus_cycle("iack_l5", 24'hFFFFFB, 3'b111, 1, 1, 0, 8'h00, 7, 3'b001, 6'h3F, 0, 8'h00, 1);
        bus_cycle("iack_l2", 24'hFFFFF5, 3'b111, 1, 1, 0, 8'h00, 3, 3'b010, 6'h3F, 0, 8'h00, 0);
    endtask

    task automatic test_berr();
        bus_cycle("unmapped", 24'h400000, 3'b101, 1, 0, 0, 8'h00, 3, 3'b100, 6'h3F, 0, 8'h00, 0);
        bus_cycle("fc7_noiack", 24'h800000, 3'b111, 1, 0, 0, 8'h00, 3, 3'b100, 6'h3F, 0, 8'h00, 0);
        bus_cycle("watchdog", 24'h000001, 3'b101, 1, 1, 0, 8'h00, 16, 3'b100, 6'b011111, 0, 8'h00, 0);
    endtask

    task automatic test_reset_mid_wait();
        val_t v;
        int   seen;
        @(negedge clk);
        addr_h = 10'h000; addr_l = 4'h0; fc = 3'b101; rw = 1'b1;
        uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({dtack, vpa, berr, iack_duart, rom_lower, rom_upper, ram_lower, ram_upper, duart, exp_cs}
            !== 10'h3FF) begin
            miscompares++;
            $display("FAIL midwait_strobes: got %b expected all ones",
                     {dtack, vpa, berr, iack_duart, rom_lower, rom_upper, ram_lower, ram_upper, duart, exp_cs});
        end
        vectors++;
        if ({data_oe, clk_cpu, led, gpio, ipl} !== {1'b0, 1'b0, 3'd0, 8'd0, 3'b111}) begin
            miscompares++;
            $display("FAIL midwait_regs: oe=%b clk_cpu=%b led=%h gpio=%h ipl=%b", data_oe, clk_cpu, led, gpio, ipl);
        end
        @(negedge clk);
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if ({dtack, vpa, berr} != 3'b111) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL post_reset_ack: got %0d acknowledged cycles expected 0", seen);
        end
        val_q.push_back('{"ipl_mask_reset", 32'(3'b010)});
        irq_n = 7'b1101011;
        repeat (4) @(posedge clk);
        #1;
        v = val_q.pop_front();
        vectors++;
        if (32'(ipl) !== v.val) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", v.name, ipl, v.val[2:0]);
        end
    endtask

    initial begin
        test_reset();
        test_memory();
        test_io_regs();
        test_irq();
        test_iack();
        test_berr();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
